// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit for a 5-stage MIPS core: stall, E flush and forwarding selects
// from shadow E/M/W hazard slots, plus the mult/div busy window for HI/LO users.
module hazard_scoreboard #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       use_rsD,
  input  logic       use_rtD,
  input  logic [1:0] tuse_rsD,
  input  logic [1:0] tuse_rtD,
  input  logic [4:0] dstD,
  input  logic       regwD,
  input  logic [2:0] tnewD,
  input  logic       md_startD,
  input  logic       md_divD,
  input  logic       md_useD,
  output logic       stall,
  output logic       clrE,
  output logic [1:0] fwd_rsD,
  output logic [1:0] fwd_rtD,
  output logic [1:0] fwd_rsE,
  output logic [1:0] fwd_rtE,
  output logic       md_busy
);

  // E slot
  logic [4:0] r_e_dst;
  logic [2:0] r_e_tnew;
  logic       r_e_regw;
  logic [4:0] r_e_rs;
  logic [4:0] r_e_rt;
  logic       r_e_md_start;
  logic       r_e_md_div;
  // M slot
  logic [4:0] r_m_dst;
  logic [2:0] r_m_tnew;
  logic       r_m_regw;
  // W slot
  logic [4:0] r_w_dst;
  logic       r_w_regw;
  // mult/div busy counter
  logic [3:0] r_md_cnt;

  // Register 0 is hardwired, so a write to it is never a real producer.
  function automatic logic slot_match(input logic regw, input logic [4:0] dst,
                                      input logic [4:0] r);
    return regw && (dst == r) && (r != 5'd0);
  endfunction

  logic w_e_hit_rsD, w_m_hit_rsD, w_w_hit_rsD;
  logic w_e_hit_rtD, w_m_hit_rtD, w_w_hit_rtD;
  logic w_m_hit_rsE, w_w_hit_rsE, w_m_hit_rtE, w_w_hit_rtE;
  logic w_stall_rs, w_stall_rt, w_stall_md;
  logic [2:0] w_m_tnew_next;

  assign w_e_hit_rsD = slot_match(r_e_regw, r_e_dst, rsD);
  assign w_m_hit_rsD = slot_match(r_m_regw, r_m_dst, rsD);
  assign w_w_hit_rsD = slot_match(r_w_regw, r_w_dst, rsD);
  assign w_e_hit_rtD = slot_match(r_e_regw, r_e_dst, rtD);
  assign w_m_hit_rtD = slot_match(r_m_regw, r_m_dst, rtD);
  assign w_w_hit_rtD = slot_match(r_w_regw, r_w_dst, rtD);
  assign w_m_hit_rsE = slot_match(r_m_regw, r_m_dst, r_e_rs);
  assign w_w_hit_rsE = slot_match(r_w_regw, r_w_dst, r_e_rs);
  assign w_m_hit_rtE = slot_match(r_m_regw, r_m_dst, r_e_rt);
  assign w_w_hit_rtE = slot_match(r_w_regw, r_w_dst, r_e_rt);

  // A producer stalls the consumer only if its result arrives later than it is needed.
  assign w_stall_rs = use_rsD &&
                      ((w_e_hit_rsD && (r_e_tnew > {1'b0, tuse_rsD})) ||
                       (w_m_hit_rsD && (r_m_tnew > {1'b0, tuse_rsD})));
  assign w_stall_rt = use_rtD &&
                      ((w_e_hit_rtD && (r_e_tnew > {1'b0, tuse_rtD})) ||
                       (w_m_hit_rtD && (r_m_tnew > {1'b0, tuse_rtD})));
  assign w_stall_md = md_useD && (md_busy || r_e_md_start);

  assign md_busy = (r_md_cnt != 4'd0);
  assign stall   = w_stall_rs || w_stall_rt || w_stall_md;
  assign clrE    = stall;

  // Youngest ready producer wins: E > M > W.
  assign fwd_rsD = (w_e_hit_rsD && (r_e_tnew == 3'd0)) ? 2'd3 :
                   (w_m_hit_rsD && (r_m_tnew == 3'd0)) ? 2'd2 :
                   w_w_hit_rsD                         ? 2'd1 : 2'd0;
  assign fwd_rtD = (w_e_hit_rtD && (r_e_tnew == 3'd0)) ? 2'd3 :
                   (w_m_hit_rtD && (r_m_tnew == 3'd0)) ? 2'd2 :
                   w_w_hit_rtD                         ? 2'd1 : 2'd0;
  assign fwd_rsE = (w_m_hit_rsE && (r_m_tnew == 3'd0)) ? 2'd2 :
                   w_w_hit_rsE                         ? 2'd1 : 2'd0;
  assign fwd_rtE = (w_m_hit_rtE && (r_m_tnew == 3'd0)) ? 2'd2 :
                   w_w_hit_rtE                         ? 2'd1 : 2'd0;

  assign w_m_tnew_next = (r_e_tnew == 3'd0) ? 3'd0 : r_e_tnew - 3'd1;

  // NOTE: all state updates use non-blocking assignments so W<-M<-E shift in one edge
  // without one stage seeing another's freshly written value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_e_dst      <= 5'd0;
      r_e_tnew     <= 3'd0;
      r_e_regw     <= 1'b0;
      r_e_rs       <= 5'd0;
      r_e_rt       <= 5'd0;
      r_e_md_start <= 1'b0;
      r_e_md_div   <= 1'b0;
      r_m_dst      <= 5'd0;
      r_m_tnew     <= 3'd0;
      r_m_regw     <= 1'b0;
      r_w_dst      <= 5'd0;
      r_w_regw     <= 1'b0;
      r_md_cnt     <= 4'd0;
    end else begin
      r_w_dst  <= r_m_dst;
      r_w_regw <= r_m_regw;
      r_m_dst  <= r_e_dst;
      r_m_tnew <= w_m_tnew_next;
      r_m_regw <= r_e_regw;

      if (stall) begin
        r_e_dst      <= 5'd0;
        r_e_tnew     <= 3'd0;
        r_e_regw     <= 1'b0;
        r_e_rs       <= 5'd0;
        r_e_rt       <= 5'd0;
        r_e_md_start <= 1'b0;
        r_e_md_div   <= 1'b0;
      end else begin
        r_e_dst      <= dstD;
        r_e_tnew     <= tnewD;
        r_e_regw     <= regwD;
        // Unused source fields are zeroed so they can never pick up a forward in E.
        r_e_rs       <= use_rsD ? rsD : 5'd0;
        r_e_rt       <= use_rtD ? rtD : 5'd0;
        r_e_md_start <= md_startD;
        r_e_md_div   <= md_divD;
      end

      if (r_e_md_start)
        r_md_cnt <= r_e_md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
      else if (r_md_cnt != 4'd0)
        r_md_cnt <= r_md_cnt - 4'd1;
    end
  end

endmodule
